// File: rtl/drive_slot_pkg.sv
// drive_slot_pkg: shared channel state type, default widths and round-robin helper.
package drive_slot_pkg;
    typedef enum logic [1:0] {CH_IDLE, CH_ON, CH_DEAD} ch_state_t;
    localparam int DEF_NUM_CH  = 16;
    localparam int DEF_PULSE_W = 16;
    localparam int DEF_DEAD_W  = 8;
    function automatic int rr_next(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction
endpackage

// File: rtl/drive_slot_if.sv
// drive_slot_if: request/config/drive bundle between sequencers and the slot arbiter.
// Stats signals exist only when DRIVE_SLOT_STATS_EN is defined.
interface drive_slot_if
    import drive_slot_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int DEAD_W  = DEF_DEAD_W
);
    localparam int CNT_W = $clog2(NUM_CH + 1);
    logic               enable;
    logic [NUM_CH-1:0]  fire_req;
    logic [NUM_CH-1:0]  fire_dir;
    logic [PULSE_W-1:0] pulse_len;
    logic [DEAD_W-1:0]  dead_len;
    logic [CNT_W-1:0]   cfg_max_active;
    logic [NUM_CH-1:0]  drive_en;
    logic [NUM_CH-1:0]  drive_dir;
    logic [CNT_W-1:0]   active_count;
    logic               busy;
    logic               cycle_done;
`ifdef DRIVE_SLOT_STATS_EN
    logic [15:0]        grant_total;
    logic [NUM_CH-1:0]  starved;
`endif
    modport master (
        output enable, fire_req, fire_dir, pulse_len, dead_len, cfg_max_active,
`ifdef DRIVE_SLOT_STATS_EN
        input  grant_total, starved,
`endif
        input  drive_en, drive_dir, active_count, busy, cycle_done
    );
    modport slave (
        input  enable, fire_req, fire_dir, pulse_len, dead_len, cfg_max_active,
`ifdef DRIVE_SLOT_STATS_EN
        output grant_total, starved,
`endif
        output drive_en, drive_dir, active_count, busy, cycle_done
    );
endinterface

// File: rtl/drive_slot_timer.sv
// drive_slot_timer: per-channel IDLE -> ON -> DEAD -> IDLE sequencer with values latched at grant.
module drive_slot_timer
    import drive_slot_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int DEAD_W  = DEF_DEAD_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               grant_i,
    input  logic               dir_i,
    input  logic [PULSE_W-1:0] pulse_len_i,
    input  logic [DEAD_W-1:0]  dead_len_i,
    output ch_state_t          state_o,
    output logic               drive_en_o,
    output logic               drive_dir_o,
    output logic               last_o
);
    localparam int CW = PULSE_W > DEAD_W ? PULSE_W : DEAD_W;
    ch_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              dir_q, dir_d;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            dead_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dead_q  <= dead_d;
            dir_q   <= dir_d;
        end
    end
    // cnt_q holds remaining cycles minus one, so zero marks the last cycle of a phase
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dead_d  = dead_q;
        dir_d   = dir_q;
        case (state_q)
            CH_IDLE: if (grant_i) begin
                state_d = CH_ON;
                cnt_d   = pulse_len_i == '0 ? '0 : CW'(pulse_len_i - 1'b1);
                dead_d  = dead_len_i;
                dir_d   = dir_i;
            end
            CH_ON: if (cnt_q == '0) begin
                state_d = dead_q == '0 ? CH_IDLE : CH_DEAD;
                cnt_d   = dead_q == '0 ? '0 : CW'(dead_q - 1'b1);
            end else cnt_d = cnt_q - 1'b1;
            CH_DEAD: if (cnt_q == '0) state_d = CH_IDLE;
                     else cnt_d = cnt_q - 1'b1;
            default: state_d = CH_IDLE;
        endcase
    end
    assign state_o     = state_q;
    assign drive_en_o  = state_q == CH_ON;
    assign drive_dir_o = dir_q;
    assign last_o      = state_q == CH_ON && cnt_q == '0;
endmodule

// File: rtl/drive_slot_arbiter.sv
// drive_slot_arbiter: round-robin grants of a bounded number of concurrent drive pulses.
// DRIVE_SLOT_STATS_EN adds grant_total and starved statistics.
module drive_slot_arbiter
    import drive_slot_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int DEAD_W  = DEF_DEAD_W
) (
    input logic        clock,
    input logic        reset,
    drive_slot_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_CH + 1);
    localparam int PTR_W = $clog2(NUM_CH);
    ch_state_t          state [NUM_CH];
    logic [NUM_CH-1:0]  idle, live, on_last, grant, drive_en, drive_dir;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, gnt_idx, p;
    logic [CNT_W-1:0]   act_q, act_d;
    logic               gnt_v, can_grant, busy, busy_q;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        drive_slot_timer #(.PULSE_W(PULSE_W), .DEAD_W(DEAD_W)) u_timer (
            .clock       (clock),
            .reset       (reset),
            .grant_i     (grant[i]),
            .dir_i       (bus.fire_dir[i]),
            .pulse_len_i (bus.pulse_len),
            .dead_len_i  (bus.dead_len),
            .state_o     (state[i]),
            .drive_en_o  (drive_en[i]),
            .drive_dir_o (drive_dir[i]),
            .last_o      (on_last[i])
        );
        assign idle[i] = state[i] == CH_IDLE;
        assign live[i] = state[i] != CH_IDLE;
    end
    // act_q counts channels in ON; a channel leaving ON frees its slot only after this edge
    always_comb begin
        can_grant = bus.enable && act_q < bus.cfg_max_active;
        gnt_v     = 1'b0;
        gnt_idx   = '0;
        p         = rr_ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (can_grant && !gnt_v && bus.fire_req[p] && idle[p]) begin
                gnt_v   = 1'b1;
                gnt_idx = p;
            end
            p = PTR_W'(rr_next(int'(p), NUM_CH));
        end
        grant    = gnt_v ? NUM_CH'(1) << gnt_idx : '0;
        rr_ptr_d = gnt_v ? PTR_W'(rr_next(int'(gnt_idx), NUM_CH)) : rr_ptr_q;
        act_d    = act_q + CNT_W'(gnt_v);
        for (int k = 0; k < NUM_CH; k++) act_d = act_d - CNT_W'(on_last[k]);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q <= '0;
            act_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            act_q    <= act_d;
            busy_q   <= busy;
        end
    end
    assign busy             = |live;
    assign bus.drive_en     = drive_en;
    assign bus.drive_dir    = drive_dir;
    assign bus.active_count = act_q;
    assign bus.busy         = busy;
    assign bus.cycle_done   = busy_q && !busy && bus.fire_req == '0;
`ifdef DRIVE_SLOT_STATS_EN
    logic [15:0]       total_q;
    logic [NUM_CH-1:0] starved_q;
    logic [CNT_W:0]    wait_q [NUM_CH];
    // wait_q counts grants given to others while this channel sits idle and requesting
    always_ff @(posedge clock) begin
        if (reset) begin
            total_q   <= '0;
            starved_q <= '0;
            for (int k = 0; k < NUM_CH; k++) wait_q[k] <= '0;
        end else begin
            if (gnt_v && total_q != '1) total_q <= total_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (!bus.fire_req[k] || !idle[k] || grant[k]) wait_q[k] <= '0;
                else if (gnt_v && wait_q[k] <= (CNT_W+1)'(NUM_CH)) wait_q[k] <= wait_q[k] + 1'b1;
                if (wait_q[k] > (CNT_W+1)'(NUM_CH)) starved_q[k] <= 1'b1;
            end
        end
    end
    assign bus.grant_total = total_q;
    assign bus.starved     = starved_q;
`endif
endmodule
